// File: rtl/imem_resp_if.sv
// Fetch request/response, flush and program-load signals of the instruction memory.
// master = fetch unit / loader side, slave = imem_resp.
interface imem_resp_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic        rsp_err;
  logic        flush;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  modport master (
    output req_valid, req_addr, rsp_ready, flush, ld_en, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, flush, ld_en, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );
endinterface

// File: rtl/imem_resp.sv
// Instruction memory with 1-cycle fetch latency, 2-deep in-order response queue,
// fault detection, flush, and a program-load write port.
module imem_resp #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic      clk,
  input  logic      rst,
  imem_resp_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 4 || DEPTH > 65536 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("imem_resp: DEPTH must be a power of two in 4..65536");
  end

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } rsp_t;

  logic [31:0] mem [DEPTH];
  logic [1:0]  cnt;
  logic        up;
  rsp_t        head, spill, fetch;
  logic        accept, pop, ld_ok;
  logic [AW-1:0] req_idx, ld_idx;

  // Word-aligned and inside the array; everything above the index bits must be zero.
  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a >> (AW + 2)) == 32'd0);
  endfunction

  assign req_idx = bus.req_addr[AW+1:2];
  assign ld_idx  = bus.ld_addr[AW+1:2];
  assign ld_ok   = bus.ld_en && addr_ok(bus.ld_addr);

  always_comb begin
    fetch       = '0;
    fetch.addr  = bus.req_addr;
    fetch.err   = !addr_ok(bus.req_addr);
    fetch.instr = fetch.err ? NOP_INSTR : mem[req_idx];
  end

  // `up` keeps req_ready low until the first edge seen out of reset.
  assign bus.req_ready = up && (cnt != 2'd2) && !bus.flush;
  assign bus.rsp_valid = (cnt != 2'd0);
  assign bus.rsp_instr = head.instr;
  assign bus.rsp_addr  = head.addr;
  assign bus.rsp_err   = head.err;

  assign accept = bus.req_valid && bus.req_ready;
  assign pop    = bus.rsp_valid && bus.rsp_ready;

  // head is the presented response; spill holds the second outstanding one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= 2'd0;
      up    <= 1'b0;
      head  <= '0;
      spill <= '0;
    end else begin
      up <= 1'b1;
      if (bus.flush) begin
        cnt <= 2'd0;
      end else begin
        case (cnt)
          2'd0: begin
            if (accept) begin
              head <= fetch;
              cnt  <= 2'd1;
            end
          end
          2'd1: begin
            if (accept && pop) begin
              head <= fetch;
            end else if (pop) begin
              cnt <= 2'd0;
            end else if (accept) begin
              spill <= fetch;
              cnt   <= 2'd2;
            end
          end
          2'd2: begin
            if (pop) begin
              head <= spill;
              cnt  <= 2'd1;
            end
          end
          default: cnt <= 2'd0;
        endcase
      end
    end
  end

  // Array is not reset; the fetch path reads the pre-edge word (read-before-write).
  always_ff @(posedge clk) begin
    if (ld_ok) mem[ld_idx] <= bus.ld_data;
  end
endmodule

// File: tb/tb_imem_resp.sv
// Randomized + directed bench for imem_resp with an in-order scoreboard and a
// word-array reference model.
module tb_imem_resp;
  localparam int DEPTH = 256;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  imem_resp_if bus();

  imem_resp #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_m [DEPTH];
  bit          rdy_m = 1'b0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit good_addr(input logic [31:0] a);
    return (a % 4 == 0) && (a < DEPTH * 4);
  endfunction

  // Scoreboard/monitor: compares DUT against the model away from the active edge,
  // then advances the model to what the coming rising edge will do.
  always @(negedge clk) begin
    bit   exp_rdy;
    exp_t e;
    if (!rst) begin
      chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      sb.delete();
      rdy_m = 1'b0;
    end else begin
      exp_rdy = rdy_m && (sb.size() < 2) && !bus.flush;
      chk("req_ready", {31'd0, bus.req_ready}, {31'd0, exp_rdy});
      chk("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, sb.size() > 0});
      if (sb.size() > 0 && bus.rsp_valid) begin
        chk("rsp_instr", bus.rsp_instr, sb[0].instr);
        chk("rsp_addr",  bus.rsp_addr,  sb[0].addr);
        chk("rsp_err",   {31'd0, bus.rsp_err}, {31'd0, sb[0].err});
      end
      if (bus.flush) begin
        sb.delete();
      end else begin
        if (bus.rsp_ready && sb.size() > 0) void'(sb.pop_front());
        if (bus.req_valid && exp_rdy) begin
          e.addr  = bus.req_addr;
          e.err   = !good_addr(bus.req_addr);
          e.instr = e.err ? NOP : mem_m[bus.req_addr / 4];
          sb.push_back(e);
        end
      end
      if (bus.ld_en && good_addr(bus.ld_addr)) mem_m[bus.ld_addr / 4] = bus.ld_data;
      rdy_m = 1'b1;
    end
  end

  always @(negedge rst) begin
    #1;
    chk("async_rst_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("async_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("async_rst_instr", bus.rsp_instr, 32'd0);
    chk("async_rst_addr",  bus.rsp_addr,  32'd0);
    chk("async_rst_err",   {31'd0, bus.rsp_err}, 32'd0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.ld_en     = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    bus.ld_en = 1'b1; bus.ld_addr = a; bus.ld_data = d;
    cyc();
    bus.ld_en = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    bus.req_valid = 1'b1; bus.req_addr = a;
    cyc();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    int r;
    bus.req_valid = 0; bus.req_addr = 0; bus.rsp_ready = 0; bus.flush = 0;
    bus.ld_en = 0; bus.ld_addr = 0; bus.ld_data = 0;
    #2 rst = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc();

    // Fill the whole array so every in-range fetch has a known expected word.
    for (int i = 0; i < DEPTH; i++) load(i * 4, $urandom);
    load(32'h0, 32'h0050_0093);
    load(32'h4, 32'h00A0_0113);

    // Back-to-back fetches with consumer always ready.
    bus.rsp_ready = 1'b1;
    fetch(32'h0);
    fetch(32'h4);
    cyc(3);

    // Stalled consumer: third request must be refused, head stays stable.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_addr = 32'h10; cyc();
    bus.req_addr = 32'h14; cyc();
    bus.req_addr = 32'h18; cyc();
    bus.req_valid = 1'b0;
    cyc(2);
    bus.rsp_ready = 1'b1;
    cyc(4);

    // Faulted fetches: misaligned and out of range.
    fetch(32'h2);
    fetch(32'h400);
    cyc(3);

    // Flush with two outstanding and a concurrent request.
    bus.rsp_ready = 1'b0;
    fetch(32'h20);
    fetch(32'h24);
    bus.flush = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 32'h28; cyc();
    bus.flush = 1'b0; bus.req_valid = 1'b0;
    cyc();
    bus.rsp_ready = 1'b1;
    fetch(32'h2C);
    cyc(3);

    // Same-edge load and fetch of one word: old value first, new value after.
    load(32'h8, NOP);
    bus.ld_en = 1'b1; bus.ld_addr = 32'h8; bus.ld_data = 32'hDEAD_BEEF;
    bus.req_valid = 1'b1; bus.req_addr = 32'h8;
    cyc();
    idle();
    fetch(32'h8);
    cyc(3);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bus.req_valid = ($urandom % 4) != 0;
      r = $urandom % 16;
      if (r == 0)      bus.req_addr = ($urandom % (DEPTH * 4)) | 32'h1;
      else if (r == 1) bus.req_addr = DEPTH * 4 + ($urandom % 4096) * 4;
      else             bus.req_addr = ($urandom % DEPTH) * 4;
      bus.rsp_ready = ($urandom % 3) != 0;
      bus.flush     = ($urandom % 40) == 0;
      bus.ld_en     = ($urandom % 8) == 0;
      r = $urandom % 8;
      bus.ld_addr   = (r == 0) ? 32'h3 : (r == 1) ? 32'h0001_0000 : ($urandom % DEPTH) * 4;
      bus.ld_data   = $urandom;
      cyc();
    end
    idle();
    bus.rsp_ready = 1'b1;
    cyc(3);

    // Asynchronous reset between edges with fetches outstanding.
    bus.rsp_ready = 1'b0;
    fetch(32'h0);
    fetch(32'h4);
    #2 rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) fetch(i * 4);
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_resp.md
IMEM_RESP -- requirements
Module: imem_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 256: instruction words stored; power of two, 4 to 65536.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000013: instruction returned on faulted fetches.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1: fetch request present.
REQ-006 SHALL have port req_addr, input, 32: byte address of requested instruction (PC value).
REQ-007 SHALL have port req_ready, output, 1: request can be accepted this cycle.
REQ-008 SHALL have port rsp_valid, output, 1: response at queue head valid.
REQ-009 SHALL have port rsp_ready, input, 1: consumer takes head response.
REQ-010 SHALL have port rsp_instr, output, 32: fetched instruction word.
REQ-011 SHALL have port rsp_addr, output, 32: req_addr of the request this response answers.
REQ-012 SHALL have port rsp_err, output, 1: fetch fault (misaligned or out of range).
REQ-013 SHALL have port flush, input, 1: discard all outstanding fetches (branch/redirect).
REQ-014 SHALL have port ld_en, input, 1: program-load write strobe.
REQ-015 SHALL have port ld_addr, input, 32: program-load byte address.
REQ-016 SHALL have port ld_data, input, 32: program-load word.

Function
REQ-017 SHALL hold a DEPTH x 32 word array; word index = addr[log2(DEPTH)+1:2].
REQ-018 SHALL accept a request on a rising edge where req_valid && req_ready; pop a response on a rising edge where rsp_valid && rsp_ready.
REQ-019 SHALL track outstanding = accepted-but-not-popped responses, range 0..2; accept and pop on the same edge leave it unchanged.
REQ-020 SHALL drive req_ready = (outstanding < 2) && !flush, from registered state and flush only; no dependence on rsp_ready or req_valid.
REQ-021 SHALL present each response at the head starting the cycle after its acceptance edge (1-cycle latency) when no older response is queued.
REQ-022 SHALL return responses strictly in acceptance order; head rsp_instr/rsp_addr/rsp_err stable while rsp_valid && !rsp_ready.
REQ-023 SHALL sustain one fetch per cycle with req_valid and rsp_ready held high (outstanding steady at 1).
REQ-024 SHALL flag fault when req_addr[1:0] != 0 or req_addr[31:log2(DEPTH)+2] != 0: rsp_err=1, rsp_instr=NOP_INSTR, array not read.
REQ-025 SHALL, non-faulted, return rsp_err=0 and the array word at the word index as of before the acceptance edge.
REQ-026 SHALL, on a rising edge with flush=1, discard all outstanding entries (outstanding=0, rsp_valid=0 next cycle), accept no request, and ignore pop.
REQ-027 SHALL, on a rising edge with ld_en=1 and ld_addr aligned and in range, write ld_data to the word; misaligned/out-of-range loads ignored.
REQ-028 SHALL, on load and accepted fetch to the same word on one edge, return the old word (read-before-write); the new word is seen by later fetches.
REQ-029 SHALL leave load writes unaffected by flush or outstanding count.

Reset
REQ-030 SHALL, while rst=0, asynchronously force outstanding=0, rsp_valid=0, rsp_instr=0, rsp_addr=0, rsp_err=0, req_ready=0.
REQ-031 SHALL keep array contents unchanged by reset; reset mid-operation drops all outstanding fetches, no partial response.
REQ-032 SHALL raise req_ready in the first cycle after rst deasserts (rst=1 sampled at an edge).

Verification
REQ-033 SHALL verify: load words 0x00500093@0x0, 0x00A00113@0x4; fetch 0x0 then 0x4 back-to-back, rsp_ready=1 -> responses 0x00500093 then 0x00A00113, one per cycle, rsp_err=0, rsp_addr 0x0/0x4.
REQ-034 SHALL verify: rsp_ready=0, req_valid=1 three cycles -> exactly two accepted, req_ready=0 third cycle; rsp_ready=1 -> both delivered in order, head stable while stalled.
REQ-035 SHALL verify: fetch 0x2 and 0x400 (DEPTH=256) -> rsp_err=1, rsp_instr=0x00000013, rsp_addr echoed.
REQ-036 SHALL verify: two outstanding, flush=1 one cycle with req_valid=1 -> no accept that edge, rsp_valid=0 next cycle, next fetch returns only new data.
REQ-037 SHALL verify: same-edge ld_en at 0x8 (0xDEADBEEF over 0x00000013) and fetch 0x8 -> 0x00000013; next fetch 0x8 -> 0xDEADBEEF.
REQ-038 SHALL verify: rst=0 asserted mid-stream between edges -> rsp_valid and req_ready drop immediately; after release, array data intact, outstanding=0.
